// File: rtl/chacha20_pkg.sv
// Shared types and constants for the ChaCha20 keystream consumer.
package chacha20_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 16;

  typedef logic [255:0] chacha_key_t;
  typedef logic [95:0]  chacha_nonce_t;
  typedef logic [31:0]  chacha_word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM
  } stream_state_t;

endpackage

// File: rtl/chacha20_stream_xor.sv
// Stream XOR stage: fetches one 512-bit keystream block at a time from the
// generator and applies it word by word to a valid/ready data stream.
module chacha20_stream_xor #(
  parameter int unsigned WORDS_PER_BLOCK = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_load,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter_init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         ks_start,
  output logic [255:0] ks_key,
  output logic [95:0]  ks_nonce,
  output logic [31:0]  ks_counter,
  input  logic [511:0] ks_keystream,
  input  logic         ks_done,
  output logic         busy,
  output logic         ctr_err
);

  import chacha20_pkg::*;

  if (WORDS_PER_BLOCK != 16) begin : g_bad_block_size
    $error("chacha20_stream_xor: WORDS_PER_BLOCK must be 16");
  end

  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLOCK - 1);

  stream_state_t state_q;
  logic [3:0]    idx_q;
  chacha_word_t  ctr_q;
  chacha_key_t   key_q;
  chacha_nonce_t nonce_q;
  chacha_word_t  buf_q [WORDS_PER_BLOCK];
  logic          out_valid_q;
  chacha_word_t  out_data_q;
  logic          out_last_q;
  logic          ks_start_q;
  logic          ctr_err_q;
  logic          ks_done_q;

  logic          in_ready_d;
  logic          accept;

  // Single output register: a new word may enter whenever the current one leaves.
  assign in_ready_d = (state_q == STREAM) && (!out_valid_q || out_ready);
  assign accept     = in_ready_d && in_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ctr_q       <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
        buf_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      ks_start_q  <= 1'b0;
      ctr_err_q   <= 1'b0;
      ks_done_q   <= 1'b0;
    end else begin
      ks_done_q  <= ks_done;
      ks_start_q <= 1'b0;

      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data ^ buf_q[idx_q];
        out_last_q  <= in_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      // ks_start is raised on every entry into REQ so it is high for exactly that cycle.
      case (state_q)
        IDLE: begin
          if (cfg_load) begin
            key_q      <= key;
            nonce_q    <= nonce;
            ctr_q      <= counter_init;
            ctr_err_q  <= 1'b0;
            idx_q      <= '0;
            ks_start_q <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (ks_done && !ks_done_q) begin
            for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
              buf_q[i] <= ks_keystream[i*32 +: 32];
            end
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            idx_q <= idx_q + 4'd1;
            if (in_last) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else if (idx_q == LAST_IDX) begin
              if (ctr_q == '1) begin
                ctr_err_q <= 1'b1;
                state_q   <= IDLE;
              end else begin
                ctr_q      <= ctr_q + 32'd1;
                ks_start_q <= 1'b1;
                state_q    <= REQ;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_d;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign ks_start   = ks_start_q;
  assign ks_key     = key_q;
  assign ks_nonce   = nonce_q;
  assign ks_counter = ctr_q;
  assign busy       = (state_q != IDLE);
  assign ctr_err    = ctr_err_q;

endmodule

// File: tb/tb_chacha20_stream_xor.sv
// Bench for chacha20_stream_xor: a ChaCha20 block-function model acts as the
// keystream generator and as the reference for every output word.
module tb_chacha20_stream_xor;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_load = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  counter_init = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         ks_start;
  logic [255:0] ks_key;
  logic [95:0]  ks_nonce;
  logic [31:0]  ks_counter;
  logic [511:0] ks_keystream = '0;
  logic         ks_done = 1'b0;
  logic         busy;
  logic         ctr_err;

  chacha20_stream_xor #(.WORDS_PER_BLOCK(16)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .key(key), .nonce(nonce),
    .counter_init(counter_init), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ks_start(ks_start), .ks_key(ks_key), .ks_nonce(ks_nonce),
    .ks_counter(ks_counter), .ks_keystream(ks_keystream), .ks_done(ks_done),
    .busy(busy), .ctr_err(ctr_err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [255:0] cur_key;
  logic [95:0]  cur_nonce;
  logic [31:0]  cur_ctr;
  logic [31:0]  msg_q[$];
  logic [31:0]  exp_q[$];
  logic [31:0]  rx_q[$];
  logic [31:0]  start_ctrs[$];
  int unsigned  n_starts = 0;
  bit           gen_hold = 1'b0;
  int unsigned  gen_cnt = 0;
  logic [511:0] gen_pending = '0;
  localparam int unsigned GEN_LAT = 4;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [127:0] qr(input logic [127:0] v);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = v;
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [31:0] ctr,
                                                input logic [95:0] n);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] res;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[i*32 +: 32];
    s[12] = ctr;
    for (int j = 0; j < 3; j++) s[13+j] = n[j*32 +: 32];
    x = s;
    for (int rnd = 0; rnd < 10; rnd++) begin
      {x[0], x[4], x[8],  x[12]} = qr({x[0], x[4], x[8],  x[12]});
      {x[1], x[5], x[9],  x[13]} = qr({x[1], x[5], x[9],  x[13]});
      {x[2], x[6], x[10], x[14]} = qr({x[2], x[6], x[10], x[14]});
      {x[3], x[7], x[11], x[15]} = qr({x[3], x[7], x[11], x[15]});
      {x[0], x[5], x[10], x[15]} = qr({x[0], x[5], x[10], x[15]});
      {x[1], x[6], x[11], x[12]} = qr({x[1], x[6], x[11], x[12]});
      {x[2], x[7], x[8],  x[13]} = qr({x[2], x[7], x[8],  x[13]});
      {x[3], x[4], x[9],  x[14]} = qr({x[3], x[4], x[9],  x[14]});
    end
    for (int i = 0; i < 16; i++) res[i*32 +: 32] = x[i] + s[i];
    return res;
  endfunction

  // Keystream generator model; in hold mode ks_done stays high between blocks
  // and only dips low for one cycle just before the next block is presented.
  always @(negedge clk) begin
    if (!reset) begin
      gen_cnt = 0;
      ks_done = 1'b0;
    end else begin
      if (ks_done && !gen_hold) ks_done = 1'b0;
      if (gen_cnt != 0) begin
        gen_cnt--;
        if (gen_hold && gen_cnt == 1) begin
          ks_done      = 1'b0;
          ks_keystream = gen_pending;
        end
        if (gen_cnt == 0) begin
          ks_keystream = gen_pending;
          ks_done      = 1'b1;
        end
      end
      if (ks_start) begin
        n_starts++;
        start_ctrs.push_back(ks_counter);
        gen_pending = chacha_block(ks_key, ks_counter, ks_nonce);
        gen_cnt     = GEN_LAT;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    cur_key = k; cur_nonce = n; cur_ctr = c;
    n_starts = 0;
    start_ctrs.delete();
    key = k; nonce = n; counter_init = c;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic fill_msg(input int unsigned n);
    msg_q.delete();
    for (int unsigned i = 0; i < n; i++) msg_q.push_back($urandom);
  endtask

  // mode 0: out_ready always 1; mode 1: random; mode 2: one 3-cycle stall after 4 outputs
  task automatic stream(input int unsigned n, input bit with_last, input int unsigned mode,
                        input int unsigned budget);
    logic [511:0] blk;
    int unsigned sent = 0, got = 0, cyc = 0, hold = 0;
    bit stalled = 1'b0;
    exp_q.delete();
    rx_q.delete();
    for (int unsigned k = 0; k < n; k++) begin
      blk = chacha_block(cur_key, cur_ctr + 32'(k / 16), cur_nonce);
      exp_q.push_back(msg_q[k] ^ blk[(k % 16)*32 +: 32]);
    end
    in_valid  = (n > 0);
    in_data   = msg_q[0];
    in_last   = with_last && (n == 1);
    out_ready = (mode != 1) || ($urandom_range(0, 3) != 0);
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (out_valid && !out_ready) chk("in_ready_backpressure", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        chk("out_data", out_data, exp_q[got]);
        chk("out_last", out_last, with_last && (got == n - 1));
        rx_q.push_back(out_data);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
      in_valid = (sent < n);
      if (sent < n) begin
        in_data = msg_q[sent];
        in_last = with_last && (sent == n - 1);
      end
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (!stalled && got == 4) begin stalled = 1'b1; hold = 3; end
          out_ready = (hold == 0);
          if (hold > 0) hold--;
        end
        default: out_ready = 1'b1;
      endcase
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("word_count", got, n);
    chk("no_extra_out", out_valid, 1'b0);
  endtask

  initial begin
    logic [255:0] rk;
    logic [255:0] k2;
    logic [95:0]  rn;
    logic [31:0]  pt_saved[$];
    logic [31:0]  ct_saved[$];
    bit           seen;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_ks_start", ks_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctr_err", ctr_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ks_key", ks_key, 256'h0);
    chk("rst_ks_nonce", ks_nonce, 96'h0);
    chk("rst_ks_counter", ks_counter, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // RFC 8439 2.4.2 vector
    for (int i = 0; i < 32; i++) rk[i*8 +: 8] = 8'(i);
    rn = 96'h0000_0000_4a00_0000_0000_0000;
    cfg(rk, rn, 32'd1);
    chk("busy_after_cfg", busy, 1'b1);
    fill_msg(5);
    msg_q[0] = 32'h6964614c;
    stream(5, 1'b1, 0, 200);
    chk("rfc_word0", rx_q[0], 32'h9a352e6e);
    chk("rfc_start_ctr", start_ctrs[0], 32'd1);
    chk("rfc_ks_key", ks_key, rk);
    chk("rfc_ks_nonce", ks_nonce, rn);
    repeat (2) @(posedge clk); #1;
    chk("idle_after_last", busy, 1'b0);

    // 17 words across a block boundary
    k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    cfg(k2, {$urandom, $urandom, $urandom}, 32'd5);
    fill_msg(17);
    stream(17, 1'b1, 0, 300);
    repeat (10) @(posedge clk); #1;
    chk("two_blk_starts", n_starts, 2);
    chk("two_blk_ctr0", start_ctrs[0], 32'd5);
    chk("two_blk_ctr1", start_ctrs[1], 32'd6);

    // backpressure stall, then decrypt back to the plaintext
    cfg(k2, 96'h1234_5678_9abc_def0_1122_3344, 32'h100);
    fill_msg(24);
    pt_saved = msg_q;
    stream(24, 1'b1, 2, 400);
    ct_saved = rx_q;
    repeat (2) @(posedge clk); #1;
    cfg(k2, 96'h1234_5678_9abc_def0_1122_3344, 32'h100);
    msg_q = ct_saved;
    stream(24, 1'b1, 1, 600);
    for (int i = 0; i < 24; i++) chk("roundtrip", rx_q[i], pt_saved[i]);

    // counter exhaustion
    repeat (2) @(posedge clk); #1;
    cfg(k2, 96'h0, 32'hFFFF_FFFF);
    fill_msg(16);
    stream(16, 1'b0, 1, 300);
    repeat (10) @(posedge clk); #1;
    chk("ovf_ctr_err", ctr_err, 1'b1);
    chk("ovf_busy", busy, 1'b0);
    chk("ovf_starts", n_starts, 1);
    cfg(k2, 96'h0, 32'h0);
    chk("ovf_err_cleared", ctr_err, 1'b0);
    fill_msg(3);
    stream(3, 1'b1, 0, 200);

    // ks_done held high across the block boundary
    repeat (2) @(posedge clk); #1;
    gen_hold = 1'b1;
    cfg(rk, rn, 32'd9);
    fill_msg(20);
    stream(20, 1'b1, 1, 500);
    chk("hold_starts", n_starts, 2);
    gen_hold = 1'b0;
    repeat (3) @(posedge clk); #1;

    // asynchronous reset while streaming with a pending output word
    cfg(k2, rn, 32'h20);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_last   = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    chk("rst_mid_reach_stream", seen, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_mid_pre_valid", out_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_out_data", out_data, 32'h0);
    chk("rst_mid_out_last", out_last, 1'b0);
    chk("rst_mid_ks_start", ks_start, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
